commit_ctrl: RTL and testbench

Retirement sequencer at the ROB head in the out-of-order core. Each cycle it inspects the oldest ROB entry and retires it in program order:
- Drives the register file's write port (write_en/reg_id/rob_id/value) so the architectural value lands and the busy tag clears.
- Hands stores to the load/store buffer and waits for completion.
- Raises the pipeline-wide flush and PC redirect on a mispredicted branch/jump.
- Latches halt.

---
 rtl/commit_ctrl.sv | 165 ++++++++++++++++
 tb/tb_commit_ctrl.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retirement sequencer at the ROB head.
// Retires at most one entry per cycle: issues register-file writes, hands
// stores to the load/store buffer, raises flush/redirect on a mispredicted
// branch or jump, and latches halt.
//
// Handshake: head_pop is a combinational dequeue strobe. The ROB must treat
// the head entry as consumed at the next rising edge of clk_in whenever
// head_pop=1. head_pop is never asserted while rdy_in=0 or rst_in=1.
module commit_ctrl #(
    parameter int ROB_W = 5,
    parameter int REG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             head_valid,
    input  logic             head_ready,
    input  logic [2:0]       head_type,
    input  logic [REG_W-1:0] head_rd,
    input  logic [31:0]      head_value,
    input  logic [ROB_W-1:0] head_id,
    input  logic             head_mispredict,
    input  logic [31:0]      head_target,
    output logic             head_pop,
    output logic             rf_write_en,
    output logic [REG_W-1:0] rf_reg_id,
    output logic [ROB_W-1:0] rf_rob_id,
    output logic [31:0]      rf_value,
    output logic             store_commit_en,
    output logic [ROB_W-1:0] store_commit_id,
    input  logic             store_done,
    output logic             flush_out,
    output logic [31:0]      redirect_pc,
    output logic             halt_out,
    output logic [31:0]      commit_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_STORE = 2'd1,
        S_FLUSH      = 2'd2,
        S_HALT       = 2'd3
    } state_t;

    localparam logic [2:0] T_STORE  = 3'd1;
    localparam logic [2:0] T_BRANCH = 3'd2;
    localparam logic [2:0] T_JUMP   = 3'd3;
    localparam logic [2:0] T_HALT   = 3'd4;

    state_t           r_state;
    logic             r_rf_write_en;
    logic [REG_W-1:0] r_rf_reg_id;
    logic [ROB_W-1:0] r_rf_rob_id;
    logic [31:0]      r_rf_value;
    logic             r_store_commit_en;
    logic [ROB_W-1:0] r_store_commit_id;
    logic             r_flush_out;
    logic [31:0]      r_redirect_pc;
    logic             r_halt_out;
    logic [31:0]      r_commit_count;

    logic w_head_go;
    logic w_is_store;
    logic w_is_branch;
    logic w_is_jump;
    logic w_is_halt;
    logic w_is_alu;
    logic w_writes_rd;
    logic w_flushes;
    logic w_pop_idle;
    logic w_pop_store;

    // Head decode; type codes 5-7 fall through to ALU.
    assign w_head_go   = head_valid && head_ready;
    assign w_is_store  = (head_type == T_STORE);
    assign w_is_branch = (head_type == T_BRANCH);
    assign w_is_jump   = (head_type == T_JUMP);
    assign w_is_halt   = (head_type == T_HALT);
    assign w_is_alu    = !(w_is_store || w_is_branch || w_is_jump || w_is_halt);
    assign w_writes_rd = (w_is_alu || w_is_jump) && (head_rd != '0);
    assign w_flushes   = (w_is_branch || w_is_jump) && head_mispredict;

    // Stores only dequeue once the LSB reports completion.
    assign w_pop_idle  = (r_state == S_IDLE) && w_head_go && !w_is_store;
    assign w_pop_store = (r_state == S_WAIT_STORE) && store_done;
    assign head_pop    = rdy_in && !rst_in && (w_pop_idle || w_pop_store);

    // Retirement FSM with registered outputs; pulses clear unless re-asserted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state           <= S_IDLE;
            r_rf_write_en     <= 1'b0;
            r_rf_reg_id       <= '0;
            r_rf_rob_id       <= '0;
            r_rf_value        <= '0;
            r_store_commit_en <= 1'b0;
            r_store_commit_id <= '0;
            r_flush_out       <= 1'b0;
            r_redirect_pc     <= '0;
            r_halt_out        <= 1'b0;
            r_commit_count    <= '0;
        end else if (rdy_in) begin
            r_rf_write_en     <= 1'b0;
            r_store_commit_en <= 1'b0;
            r_flush_out       <= 1'b0;
            if (head_pop) begin
                r_commit_count <= r_commit_count + 32'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_head_go) begin
                        if (w_is_store) begin
                            r_store_commit_en <= 1'b1;
                            r_store_commit_id <= head_id;
                            r_state           <= S_WAIT_STORE;
                        end else if (w_is_halt) begin
                            r_halt_out <= 1'b1;
                            r_state    <= S_HALT;
                        end else begin
                            if (w_writes_rd) begin
                                r_rf_write_en <= 1'b1;
                                r_rf_reg_id   <= head_rd;
                                r_rf_rob_id   <= head_id;
                                r_rf_value    <= head_value;
                            end
                            if (w_flushes) begin
                                r_flush_out   <= 1'b1;
                                r_redirect_pc <= head_target;
                                r_state       <= S_FLUSH;
                            end
                        end
                    end
                end
                S_WAIT_STORE: begin
                    if (store_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rf_write_en     = r_rf_write_en;
    assign rf_reg_id       = r_rf_reg_id;
    assign rf_rob_id       = r_rf_rob_id;
    assign rf_value        = r_rf_value;
    assign store_commit_en = r_store_commit_en;
    assign store_commit_id = r_store_commit_id;
    assign flush_out       = r_flush_out;
    assign redirect_pc     = r_redirect_pc;
    assign halt_out        = r_halt_out;
    assign commit_count    = r_commit_count;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_commit_ctrl.sv
// Testbench for commit_ctrl: directed scenarios plus randomized programs
// retired through a small ROB emulation and checked against a program-order
// model of what must retire.
module tb_commit_ctrl;

    localparam logic [2:0] T_ALU    = 3'd0;
    localparam logic [2:0] T_STORE  = 3'd1;
    localparam logic [2:0] T_BRANCH = 3'd2;
    localparam logic [2:0] T_JUMP   = 3'd3;
    localparam logic [2:0] T_HALT   = 3'd4;

    typedef struct {
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [4:0]  id;
        logic        mis;
        logic [31:0] tgt;
    } instr_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        head_valid = 1'b0;
    logic        head_ready = 1'b0;
    logic [2:0]  head_type = '0;
    logic [4:0]  head_rd = '0;
    logic [31:0] head_value = '0;
    logic [4:0]  head_id = '0;
    logic        head_mispredict = 1'b0;
    logic [31:0] head_target = '0;
    logic        store_done = 1'b0;
    logic        head_pop;
    logic        rf_write_en;
    logic [4:0]  rf_reg_id;
    logic [4:0]  rf_rob_id;
    logic [31:0] rf_value;
    logic        store_commit_en;
    logic [4:0]  store_commit_id;
    logic        flush_out;
    logic [31:0] redirect_pc;
    logic        halt_out;
    logic [31:0] commit_count;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    commit_ctrl #(.ROB_W(5), .REG_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
        .head_rd(head_rd), .head_value(head_value), .head_id(head_id),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .head_pop(head_pop), .rf_write_en(rf_write_en), .rf_reg_id(rf_reg_id),
        .rf_rob_id(rf_rob_id), .rf_value(rf_value),
        .store_commit_en(store_commit_en), .store_commit_id(store_commit_id),
        .store_done(store_done), .flush_out(flush_out), .redirect_pc(redirect_pc),
        .halt_out(halt_out), .commit_count(commit_count), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    // Driver tasks. Inputs change 1 time unit after posedge; outputs are
    // checked at negedge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_head(input logic v, input logic [2:0] t, input logic [4:0] rd,
                            input logic [31:0] val, input logic [4:0] id,
                            input logic mis, input logic [31:0] tgt);
        head_valid = v;
        head_ready = v;
        head_type = t;
        head_rd = rd;
        head_value = val;
        head_id = id;
        head_mispredict = mis;
        head_target = tgt;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        store_done = 1'b0;
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        set_head(1'b1, T_ALU, 5'd3, 32'h1234, 5'd1, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b0) begin
            fails++; $display("FAIL reset_pop: got %b want 0", head_pop);
        end
        tick();
        @(negedge clk_in);
        tests++;
        if ({rf_write_en, rf_reg_id, rf_rob_id, rf_value, store_commit_en, store_commit_id,
             flush_out, redirect_pc, halt_out, commit_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: we=%b reg=%0d rob=%0d val=%h st=%b sid=%0d fl=%b pc=%h halt=%b cnt=%0d want all 0",
                     rf_write_en, rf_reg_id, rf_rob_id, rf_value, store_commit_en, store_commit_id,
                     flush_out, redirect_pc, halt_out, commit_count);
        end
        tick();
        rst_in = 1'b0;
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_alu_burst();
        logic [4:0]  rds[3];
        logic [31:0] vals[3];
        logic [4:0]  ids[3];
        rds = '{5'd1, 5'd2, 5'd3};
        vals = '{32'h11, 32'h22, 32'h33};
        ids = '{5'd4, 5'd5, 5'd6};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_head(1'b1, T_ALU, rds[i], vals[i], ids[i], 1'b0, 32'd0);
            else set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
            @(negedge clk_in);
            tests++;
            if (head_pop !== (i < 3)) begin
                fails++; $display("FAIL burst_pop[%0d]: got %b want %b", i, head_pop, (i < 3));
            end
            if (i >= 1 && i <= 3) begin
                tests++;
                if ({rf_write_en, rf_reg_id, rf_rob_id, rf_value} !== {1'b1, rds[i-1], ids[i-1], vals[i-1]}) begin
                    fails++;
                    $display("FAIL burst_write[%0d]: got we=%b reg=%0d rob=%0d val=%h want 1/%0d/%0d/%h",
                             i, rf_write_en, rf_reg_id, rf_rob_id, rf_value, rds[i-1], ids[i-1], vals[i-1]);
                end
            end
            if (i == 4) begin
                tests++;
                if (rf_write_en !== 1'b0 || commit_count !== 32'd3) begin
                    fails++; $display("FAIL burst_end: we=%b cnt=%0d want 0/3", rf_write_en, commit_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        set_head(1'b1, T_ALU, 5'd0, 32'hDEAD, 5'd2, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b1) begin
            fails++; $display("FAIL rd0_pop: got %b want 1", head_pop);
        end
        tick();
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (rf_write_en !== 1'b0 || commit_count !== 32'd1) begin
            fails++; $display("FAIL rd0_write: we=%b cnt=%0d want 0/1", rf_write_en, commit_count);
        end
        tick();
    endtask

    task automatic test_store();
        do_reset();
        // store_done in the issuing cycle must be ignored
        set_head(1'b1, T_STORE, 5'd0, 32'd0, 5'd7, 1'b0, 32'd0);
        store_done = 1'b1;
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b0) begin
            fails++; $display("FAIL store_issue_pop: got %b want 0", head_pop);
        end
        tick();
        store_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_in);
            tests++;
            if (head_pop !== 1'b0 || store_commit_en !== (c == 1) ||
                (c == 1 && store_commit_id !== 5'd7)) begin
                fails++;
                $display("FAIL store_wait[%0d]: pop=%b en=%b id=%0d want 0/%b/7",
                         c, head_pop, store_commit_en, store_commit_id, (c == 1));
            end
            tick();
        end
        store_done = 1'b1;
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b1) begin
            fails++; $display("FAIL store_done_pop: got %b want 1", head_pop);
        end
        tick();
        store_done = 1'b0;
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (commit_count !== 32'd1 || rf_write_en !== 1'b0 || head_pop !== 1'b0) begin
            fails++; $display("FAIL store_after: cnt=%0d we=%b pop=%b want 1/0/0", commit_count, rf_write_en, head_pop);
        end
        tick();
        set_head(1'b1, T_ALU, 5'd9, 32'h99, 5'd8, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b1) begin
            fails++; $display("FAIL store_back_idle: pop=%b want 1", head_pop);
        end
        tick();
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (rf_write_en !== 1'b1 || rf_reg_id !== 5'd9 || commit_count !== 32'd2) begin
            fails++; $display("FAIL store_next_alu: we=%b reg=%0d cnt=%0d want 1/9/2", rf_write_en, rf_reg_id, commit_count);
        end
        tick();
    endtask

    task automatic test_jump_mispredict();
        do_reset();
        set_head(1'b1, T_JUMP, 5'd1, 32'h1004, 5'd3, 1'b1, 32'h2000);
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b1) begin
            fails++; $display("FAIL jump_pop: got %b want 1", head_pop);
        end
        tick();
        set_head(1'b1, T_ALU, 5'd4, 32'h44, 5'd4, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if ({rf_write_en, rf_reg_id, rf_rob_id, rf_value, flush_out, redirect_pc} !==
            {1'b1, 5'd1, 5'd3, 32'h1004, 1'b1, 32'h2000}) begin
            fails++;
            $display("FAIL jump_flush: we=%b reg=%0d rob=%0d val=%h fl=%b pc=%h want 1/1/3/1004/1/2000",
                     rf_write_en, rf_reg_id, rf_rob_id, rf_value, flush_out, redirect_pc);
        end
        tests++;
        if (head_pop !== 1'b0) begin
            fails++; $display("FAIL jump_flush_pop: got %b want 0", head_pop);
        end
        tick();
        @(negedge clk_in);
        tests++;
        if (flush_out !== 1'b0 || head_pop !== 1'b1 || commit_count !== 32'd1) begin
            fails++; $display("FAIL jump_resume: fl=%b pop=%b cnt=%0d want 0/1/1", flush_out, head_pop, commit_count);
        end
        tick();
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic test_pause();
        do_reset();
        set_head(1'b1, T_ALU, 5'd5, 32'h55, 5'd9, 1'b0, 32'd0);
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            tests++;
            if (head_pop !== 1'b0 || commit_count !== 32'd0 || rf_write_en !== 1'b0) begin
                fails++; $display("FAIL pause[%0d]: pop=%b cnt=%0d we=%b want 0/0/0", c, head_pop, commit_count, rf_write_en);
            end
            tick();
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b1) begin
            fails++; $display("FAIL pause_resume_pop: got %b want 1", head_pop);
        end
        tick();
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (rf_write_en !== 1'b1 || rf_value !== 32'h55 || commit_count !== 32'd1) begin
            fails++; $display("FAIL pause_resume_write: we=%b val=%h cnt=%0d want 1/55/1", rf_write_en, rf_value, commit_count);
        end
        tick();
    endtask

    task automatic test_halt_and_reset();
        do_reset();
        set_head(1'b1, T_HALT, 5'd0, 32'd0, 5'd2, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b1) begin
            fails++; $display("FAIL halt_pop: got %b want 1", head_pop);
        end
        tick();
        set_head(1'b1, T_ALU, 5'd6, 32'h66, 5'd3, 1'b0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            tests++;
            if (halt_out !== 1'b1 || head_pop !== 1'b0 || commit_count !== 32'd1 || rf_write_en !== 1'b0) begin
                fails++;
                $display("FAIL halt_sticky[%0d]: halt=%b pop=%b cnt=%0d we=%b want 1/0/1/0",
                         c, halt_out, head_pop, commit_count, rf_write_en);
            end
            tick();
        end
        // Second run: reset while waiting on a store
        do_reset();
        set_head(1'b1, T_STORE, 5'd0, 32'd0, 5'd7, 1'b0, 32'd0);
        tick();
        @(negedge clk_in);
        tests++;
        if (store_commit_en !== 1'b1) begin
            fails++; $display("FAIL rst_store_issue: en=%b want 1", store_commit_en);
        end
        tick();
        rst_in = 1'b1;
        store_done = 1'b1;
        @(negedge clk_in);
        tests++;
        if (head_pop !== 1'b0) begin
            fails++; $display("FAIL rst_wait_pop: got %b want 0", head_pop);
        end
        tick();
        rst_in = 1'b0;
        store_done = 1'b0;
        set_head(1'b1, T_ALU, 5'd8, 32'h88, 5'd1, 1'b0, 32'd0);
        @(negedge clk_in);
        tests++;
        if ({rf_write_en, store_commit_en, flush_out, halt_out, commit_count, store_commit_id} !== '0 ||
            head_pop !== 1'b1) begin
            fails++;
            $display("FAIL rst_wait_idle: we=%b st=%b fl=%b halt=%b cnt=%0d sid=%0d pop=%b want 0s and pop 1",
                     rf_write_en, store_commit_en, flush_out, halt_out, commit_count, store_commit_id, head_pop);
        end
        tick();
        set_head(1'b0, T_ALU, 5'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    endtask

    // Random programs: the bench plays the ROB. What must retire is the
    // program prefix up to and including the first mispredict.
    task automatic test_random(input int prog);
        instr_t        rob_q[$];
        logic [41:0]   exp_q[$];
        logic [4:0]    exp_store_q[$];
        instr_t        ins;
        instr_t        popped;
        int            n;
        int            r;
        int            exp_len = 0;
        logic          exp_flush = 1'b0;
        logic [31:0]   exp_tgt = '0;
        logic [4:0]    next_id;
        int            pops = 0;
        logic          flush_seen = 1'b0;
        int            sd_cnt = -1;
        logic          prev_rdy;
        int            drain = 0;
        int            cyc = 0;

        n = $urandom_range(8, 20);
        next_id = 5'($urandom_range(0, 31));
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) ins.typ = (r < 3) ? T_ALU : 3'($urandom_range(5, 7));
            else if (r < 6) ins.typ = T_STORE;
            else if (r < 8) ins.typ = T_BRANCH;
            else ins.typ = T_JUMP;
            ins.rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ins.val = $urandom;
            ins.id = next_id;
            next_id = next_id + 5'd1;
            ins.mis = (ins.typ == T_BRANCH || ins.typ == T_JUMP) && ($urandom_range(0, 5) == 0);
            ins.tgt = $urandom;
            rob_q.push_back(ins);
            if (!exp_flush) begin
                exp_len++;
                if (ins.typ == T_STORE) exp_store_q.push_back(ins.id);
                else if (ins.typ != T_BRANCH && ins.rd != 5'd0) exp_q.push_back({ins.rd, ins.id, ins.val});
                if (ins.mis) begin
                    exp_flush = 1'b1;
                    exp_tgt = ins.tgt;
                end
            end
        end

        do_reset();
        while (drain < 4 && cyc < 3000) begin
            cyc++;
            prev_rdy = rdy_in;
            rdy_in = (rob_q.size() == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
            if (sd_cnt > 0) sd_cnt--;
            store_done = (sd_cnt == 0);
            if (rob_q.size() > 0) begin
                set_head(1'b1, rob_q[0].typ, rob_q[0].rd, rob_q[0].val, rob_q[0].id, rob_q[0].mis, rob_q[0].tgt);
                head_ready = ($urandom_range(0, 3) != 0);
            end else begin
                set_head(1'b0, 3'($urandom_range(0, 7)), 5'($urandom), $urandom, 5'($urandom), 1'b0, $urandom);
                head_ready = $urandom_range(0, 1) != 0;
                drain++;
            end
            @(negedge clk_in);
            if (head_pop) begin
                tests++;
                if (!head_valid || rob_q.size() == 0) begin
                    fails++; $display("FAIL rand%0d_pop_empty: pop=1 with valid=%b", prog, head_valid);
                end else begin
                    popped = rob_q.pop_front();
                    if (popped.typ == T_STORE) sd_cnt = -1;
                end
                pops++;
            end
            if (prev_rdy) begin
                if (rf_write_en) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++; $display("FAIL rand%0d_write_extra: reg=%0d rob=%0d", prog, rf_reg_id, rf_rob_id);
                    end else if ({rf_reg_id, rf_rob_id, rf_value} !== exp_q[0]) begin
                        fails++;
                        $display("FAIL rand%0d_write: got %0d/%0d/%h want %0d/%0d/%h", prog,
                                 rf_reg_id, rf_rob_id, rf_value, exp_q[0][41:37], exp_q[0][36:32], exp_q[0][31:0]);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
                if (store_commit_en) begin
                    tests++;
                    if (exp_store_q.size() == 0) begin
                        fails++; $display("FAIL rand%0d_store_extra: id=%0d", prog, store_commit_id);
                    end else begin
                        if (store_commit_id !== exp_store_q[0]) begin
                            fails++; $display("FAIL rand%0d_store_id: got %0d want %0d", prog, store_commit_id, exp_store_q[0]);
                        end
                        void'(exp_store_q.pop_front());
                    end
                    sd_cnt = $urandom_range(0, 4);
                end
                if (flush_out) begin
                    tests++;
                    if (!exp_flush || flush_seen || redirect_pc !== exp_tgt) begin
                        fails++; $display("FAIL rand%0d_flush: pc=%h want %h (expected=%b seen=%b)",
                                          prog, redirect_pc, exp_tgt, exp_flush, flush_seen);
                    end
                    flush_seen = 1'b1;
                    rob_q.delete();
                end
            end
            tick();
        end
        tests++;
        if (cyc >= 3000) begin
            fails++; $display("FAIL rand%0d_timeout: %0d cycles, rob left %0d", prog, cyc, rob_q.size());
        end
        tests++;
        if (pops != exp_len || commit_count !== 32'(exp_len)) begin
            fails++; $display("FAIL rand%0d_count: pops=%0d cnt=%0d want %0d", prog, pops, commit_count, exp_len);
        end
        tests++;
        if (exp_q.size() != 0 || exp_store_q.size() != 0 || flush_seen != exp_flush) begin
            fails++; $display("FAIL rand%0d_leftover: writes=%0d stores=%0d flush=%b want 0/0/%b",
                              prog, exp_q.size(), exp_store_q.size(), flush_seen, exp_flush);
        end
        store_done = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_alu_burst();
        test_rd_zero();
        test_store();
        test_jump_mispredict();
        test_pause();
        test_halt_and_reset();
        for (int p = 0; p < 6; p++) test_random(p);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
